bram_l17_ctrl: RTL

Sequencer for the layer-17 activation buffer (8 lanes × 16-bit, dual-port, shared write enable, 10-bit address). It runs one fill-then-drain pass per `start`:

- **Fill:** pixel pairs from the upstream layer are written through both ports in parallel.
- **Drain:** the pairs are streamed back to the next layer through both ports with valid/ready backpressure.

It owns every address, data-in and write-enable line of the buffer. It sits between the layer-16 output stage and the layer-18 input stage.

---
 rtl/bram_l17_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bram_l17_ctrl.sv
// Fill-then-drain sequencer for the layer-17 activation buffer.
// Writes pixel pairs through both ports, then streams them back with valid/ready.
module bram_l17_ctrl #(
  parameter int unsigned N_BRAM = 8,
  parameter int unsigned AW     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        num_pairs,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_BRAM*16-1:0] in_data1,
  input  logic [N_BRAM*16-1:0] in_data2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [N_BRAM*16-1:0] out_data1,
  output logic [N_BRAM*16-1:0] out_data2,
  output logic [AW-1:0]        bram_addr1,
  output logic [AW-1:0]        bram_addr2,
  output logic [N_BRAM*16-1:0] bram_in1,
  output logic [N_BRAM*16-1:0] bram_in2,
  output logic                 bram_wr,
  input  logic [N_BRAM*16-1:0] bram_out1,
  input  logic [N_BRAM*16-1:0] bram_out2,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DW = N_BRAM * 16;
  localparam int unsigned CW = AW - 1;

  typedef enum logic [2:0] {StIdle, StFill, StFlush, StPrime, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   n_q, n_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   wp_q, wp_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   din1_q, din1_d;
  logic [DW-1:0]   din2_q, din2_d;

  logic [AW-1:0]   n_m1;
  logic            fill_last;
  logic            last_pair;
  logic            hs;
  logic [CW-1:0]   rd_sel;

  assign n_m1      = n_q - AW'(1);
  assign fill_last = ({1'b0, cnt_q} == n_m1);
  assign last_pair = ({1'b0, rd_ptr_q} == n_m1);
  assign hs        = (state_q == StDrain) & out_ready & ~last_pair;
  // Look one pair ahead on a handshake so the read lands for the next cycle.
  assign rd_sel    = rd_ptr_q + CW'(hs);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wp_d     = wp_q;
    wr_d     = 1'b0;
    din1_d   = din1_q;
    din2_d   = din2_q;
    unique case (state_q)
      StIdle: begin
        if (start && (num_pairs != '0)) begin
          n_d     = num_pairs;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (in_valid) begin
          wr_d   = 1'b1;
          wp_d   = cnt_q;
          din1_d = in_data1;
          din2_d = in_data2;
          cnt_d  = cnt_q + CW'(1);
          if (fill_last) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        state_d = StPrime;
      end
      StPrime: begin
        rd_ptr_d = '0;
        state_d  = StDrain;
      end
      StDrain: begin
        if (out_ready) begin
          if (last_pair) begin
            state_d = StIdle;
          end else begin
            rd_ptr_d = rd_ptr_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      n_q      <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wp_q     <= '0;
      wr_q     <= 1'b0;
      din1_q   <= '0;
      din2_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wp_q     <= wp_d;
      wr_q     <= wr_d;
      din1_q   <= din1_d;
      din2_q   <= din2_d;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data1  = '0;
    out_data2  = '0;
    bram_addr1 = '0;
    bram_addr2 = '0;
    bram_in1   = '0;
    bram_in2   = '0;
    bram_wr    = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle: ;
      StFill, StFlush: begin
        in_ready   = (state_q == StFill);
        bram_wr    = wr_q;
        bram_addr1 = {wp_q, 1'b0};
        bram_addr2 = {wp_q, 1'b1};
        bram_in1   = din1_q;
        bram_in2   = din2_q;
      end
      StPrime: begin
        bram_addr1 = '0;
        bram_addr2 = AW'(1);
      end
      StDrain: begin
        out_valid  = 1'b1;
        out_last   = last_pair;
        out_data1  = bram_out1;
        out_data2  = bram_out2;
        bram_addr1 = {rd_sel, 1'b0};
        bram_addr2 = {rd_sel, 1'b1};
        done       = out_ready & last_pair;
      end
      default: ;
    endcase
  end

endmodule
